// File: rtl/envelope_smoother_pkg.sv
// Shared constants for the envelope smoothing block: sample format and saturation value.
package envelope_smoother_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned FracBits = 29;
  localparam logic [DataW-1:0] SatValue = 32'h7FFF_FFFF;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/envelope_smoother_if.sv
// Envelope sample input, FIFO read side and status of the envelope smoother.
interface envelope_smoother_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 32
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [LevelW-1:0] level;
  logic              overflow;
  logic              ovf_clr;

  modport master (
    output in_data, in_valid, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, level, overflow
  );

  modport slave (
    input  in_data, in_valid, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, level, overflow
  );
endinterface

// File: rtl/envelope_smoother_sync_fifo.sv
// Synchronous FIFO with registered read; a push into a full FIFO without a pop is dropped.
module envelope_smoother_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     pop_valid_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);
  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == (AddrW + 1)'(DEPTH));
    level_o = count_q;
    do_pop  = pop_i && !empty_o;
    // A pop frees the head slot this edge, so a push into a full FIFO is still taken.
    do_push = push_i && (!full_o || do_pop);
    drop_o  = push_i && full_o && !do_pop;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_data_o  <= '0;
      pop_valid_o <= 1'b0;
    end else begin
      pop_valid_o <= do_pop;
      if (do_pop) begin
        pop_data_o <= mem_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/envelope_smoother.sv
// Power-of-two moving average over the envelogram, queued in a FIFO for the CPU.
// Optional running peak output enabled by defining ENV_SMOOTHER_PEAK_EN.
module envelope_smoother
  import envelope_smoother_pkg::*;
#(
  parameter int unsigned WIN_LEN    = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned DATA_W     = DataW
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef ENV_SMOOTHER_PEAK_EN
  output logic [DATA_W-1:0] peak_value,
  input  logic              peak_clr,
`endif
  envelope_smoother_if.slave bus
);
  localparam int unsigned WinLog2 = log2_ceil(WIN_LEN);
  localparam int unsigned SmpW    = DATA_W - 1;
  localparam int unsigned AccW    = SmpW + WinLog2;

  // Sanitised samples are non-negative, so the sign bit is never stored.
  logic [SmpW-1:0]    hist_q [WIN_LEN];
  logic [SmpW-1:0]    smp, old_smp;
  logic [WinLog2-1:0] ptr_q;
  logic [WinLog2:0]   fill_q;
  logic [AccW-1:0]    acc_q, acc_d;
  logic               acc_valid_q, avg_valid_q;
  logic [DATA_W-1:0]  avg_q;
  logic               fifo_drop;
  logic               overflow_q;

  always_comb begin
    smp     = bus.in_data[DATA_W-1] ? '1 : bus.in_data[SmpW-1:0];
    old_smp = fill_q[WinLog2] ? hist_q[ptr_q] : '0;
    acc_d   = acc_q + AccW'(smp) - AccW'(old_smp);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q       <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      acc_valid_q <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_q       <= '0;
    end else begin
      acc_valid_q <= bus.in_valid;
      avg_valid_q <= acc_valid_q;
      if (bus.in_valid) begin
        acc_q <= acc_d;
        ptr_q <= ptr_q + 1'b1;
        if (!fill_q[WinLog2]) begin
          fill_q <= fill_q + 1'b1;
        end
      end
      if (acc_valid_q) begin
        avg_q <= DATA_W'(acc_q >> WinLog2);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (bus.in_valid) begin
      hist_q[ptr_q] <= smp;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.overflow = overflow_q;

`ifdef ENV_SMOOTHER_PEAK_EN
  logic [DATA_W-1:0] peak_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      peak_q <= '0;
    end else if (avg_valid_q && (peak_clr || (avg_q > peak_q))) begin
      peak_q <= avg_q;
    end else if (peak_clr) begin
      peak_q <= '0;
    end
  end

  assign peak_value = peak_q;
`endif

  envelope_smoother_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (avg_valid_q),
    .push_data_i (avg_q),
    .pop_i       (bus.rd_en),
    .pop_data_o  (bus.rd_data),
    .pop_valid_o (bus.rd_valid),
    .empty_o     (bus.empty),
    .full_o      (bus.full),
    .level_o     (bus.level),
    .drop_o      (fifo_drop)
  );

endmodule

// File: tb/tb_envelope_smoother.sv
// Directed bench for envelope_smoother with WIN_LEN=4, FIFO_DEPTH=4.
module tb_envelope_smoother;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  envelope_smoother_if #(.DATA_W(32), .FIFO_DEPTH(4)) bus ();

`ifdef ENV_SMOOTHER_PEAK_EN
  logic [31:0] peak_value;
  logic        peak_clr;
`endif

  envelope_smoother #(
    .WIN_LEN    (4),
    .FIFO_DEPTH (4),
    .DATA_W     (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
`ifdef ENV_SMOOTHER_PEAK_EN
    .peak_value (peak_value),
    .peak_clr   (peak_clr),
`endif
    .bus        (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check({name, "_valid"}, 64'(bus.rd_valid), 64'd1);
    check(name, 64'(bus.rd_data), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    logic [31:0] got [$];
    logic [31:0] exp;
    logic [31:0] ovf_vals [5];
    logic [31:0] drain [4];

    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.ovf_clr  = 1'b0;
`ifdef ENV_SMOOTHER_PEAK_EN
    peak_clr = 1'b0;
`endif

    vecs[0]  = '{1'b1, 32'd4,          32'd1};
    vecs[1]  = '{1'b0, 32'd8,          32'd3};
    vecs[2]  = '{1'b0, 32'd12,         32'd6};
    vecs[3]  = '{1'b0, 32'd16,         32'd10};
    vecs[4]  = '{1'b0, 32'd20,         32'd14};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'h1FFF_FFFF};
    vecs[6]  = '{1'b0, 32'hFFFF_FFF0,  32'h3FFF_FFFF};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFF,  32'h5FFF_FFFF};
    vecs[8]  = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF};
    vecs[9]  = '{1'b0, 32'd0,          32'h5FFF_FFFF};
    vecs[10] = '{1'b1, 32'd100,        32'd25};
    vecs[11] = '{1'b0, 32'd0,          32'd25};
    vecs[12] = '{1'b0, 32'd0,          32'd25};
    vecs[13] = '{1'b0, 32'd0,          32'd25};
    vecs[14] = '{1'b0, 32'd0,          32'd0};
    vecs[15] = '{1'b0, 32'd7,          32'd1};

    // Reset state
    do_reset();
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
`ifdef ENV_SMOOTHER_PEAK_EN
    check("rst_peak", 64'(peak_value), 64'd0);
`endif

    // Two-edge latency from acceptance to FIFO
    push(32'd4);
    check("lat_n_level", 64'(bus.level), 64'd0);
    step();
    check("lat_n1_level", 64'(bus.level), 64'd0);
    step();
    check("lat_n2_level", 64'(bus.level), 64'd1);
    check("lat_n2_empty", 64'(bus.empty), 64'd0);
    pop_check("lat_pop", 32'd1);

    // Table: one push, let it land, pop it
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) do_reset();
      push(vecs[i].din);
      step();
      step();
      pop_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Back-to-back stream with continuous reads
    do_reset();
    first = -1;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = (c < 12);
      bus.in_data  = 32'h40;
      bus.rd_en    = 1'b1;
      step();
      if (bus.rd_valid) begin
        if (first < 0) first = c;
        got.push_back(bus.rd_data);
      end
    end
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    check("wrap_count", 64'(got.size()), 64'd12);
    check("wrap_first", 64'(first), 64'd3);
    for (int k = 0; k < got.size(); k++) begin
      exp = (k < 3) ? 32'((k + 1) * 16) : 32'h40;
      check($sformatf("wrap%0d", k), 64'(got[k]), 64'(exp));
    end
    check("wrap_overflow", 64'(bus.overflow), 64'd0);

    // Fill and overflow
    do_reset();
    ovf_vals = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
    for (int i = 0; i < 5; i++) begin
      bus.in_data  = ovf_vals[i];
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("ovf_full", 64'(bus.full), 64'd1);
    check("ovf_level", 64'(bus.level), 64'd4);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 64'(bus.overflow), 64'd0);

    // Clear coincident with a drop: set wins (average 18 is dropped)
    push(32'd24);
    step();
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("ovf_set_wins", 64'(bus.overflow), 64'd1);
    check("ovf_set_level", 64'(bus.level), 64'd4);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("ovf_clr2", 64'(bus.overflow), 64'd0);

    // Push and pop on the same edge while full (average 22 stored)
    push(32'd28);
    step();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("pp_valid", 64'(bus.rd_valid), 64'd1);
    check("pp_data", 64'(bus.rd_data), 64'd1);
    check("pp_level", 64'(bus.level), 64'd4);
    check("pp_full", 64'(bus.full), 64'd1);
    check("pp_overflow", 64'(bus.overflow), 64'd0);
    drain = '{32'd3, 32'd6, 32'd10, 32'd22};
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("drain%0d", i), drain[i]);
    end
    check("drain_empty", 64'(bus.empty), 64'd1);
`ifdef ENV_SMOOTHER_PEAK_EN
    check("peak_incl_drop", 64'(peak_value), 64'd22);
`endif

    // Reads while empty
    for (int i = 0; i < 3; i++) begin
      bus.rd_en = 1'b1;
      step();
      check($sformatf("er_valid%0d", i), 64'(bus.rd_valid), 64'd0);
      check($sformatf("er_data%0d", i), 64'(bus.rd_data), 64'd22);
      check($sformatf("er_level%0d", i), 64'(bus.level), 64'd0);
    end
    bus.rd_en = 1'b0;

    // Reset with averages in flight
    for (int i = 0; i < 6; i++) begin
      bus.in_data  = 32'((i + 1) * 4);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    do_reset();
    check("mr_empty", 64'(bus.empty), 64'd1);
    check("mr_level", 64'(bus.level), 64'd0);
`ifdef ENV_SMOOTHER_PEAK_EN
    check("mr_peak", 64'(peak_value), 64'd0);
`endif
    step();
    step();
    step();
    check("mr_level_late", 64'(bus.level), 64'd0);
    push(32'd8);
    step();
    step();
    pop_check("mr_restart", 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_smoother.md
Name: envelope_smoother

Overview:
- Consumes the envelogram stream (Q2.29 absolute DWT level-3 samples, qualified by a one-cycle valid strobe) produced by the wavelet stage.
- Applies a power-of-two moving-average filter and queues the smoothed samples in a synchronous FIFO.
- The AIRISC core drains the FIFO through a pop/valid handshake for segmentation.

Parameters:
- WIN_LEN, 16, moving-average window length in samples; power of two, 2..256.
- FIFO_DEPTH, 32, output FIFO entries; power of two, >=2.
- DATA_W, 32, sample width, signed Q2.29.

Ports:
- CLK  in  1  system clock, single domain.
- RST  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  envelope sample, expected non-negative.
- in_valid  in  1  one-cycle strobe; sample accepted on the CLK edge where high.
- rd_en  in  1  pop request from CPU side.
- rd_data  out  DATA_W  popped smoothed sample.
- rd_valid  out  1  high one cycle when rd_data is updated.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  sticky: a push was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, empty=1, full=0, level=0, overflow=0. Accumulator, history write pointer and fill counter are 0. History storage is not cleared.
- Input sanitising: in_data with MSB set is replaced by 0x7FFFFFFF. This covers abs(-2^31) wrap and any negative input.
- Window: circular history of WIN_LEN registers, write pointer wraps modulo WIN_LEN.
- On each accepted sample x: old = (fill_cnt < WIN_LEN) ? 0 : hist[ptr]; acc <= acc + x - old; hist[ptr] <= x; ptr++; fill_cnt saturates at WIN_LEN.
- Warm-up uses zero padding: the first outputs ramp up, and no output is suppressed.
- Accumulator is unsigned, DATA_W-1+log2(WIN_LEN) bits, so it cannot overflow.
- Output sample = acc_new >> log2(WIN_LEN), truncating, and always fits DATA_W as a non-negative value.
- Latency: sample accepted at edge N; average registered at edge N+1; pushed into the FIFO at edge N+2, so empty/level update after N+2.
- Back-to-back in_valid on every cycle is supported at full throughput.
- FIFO pop: rd_en && !empty at edge M gives rd_data = head and rd_valid=1 after M; rd_valid=0 otherwise.
- rd_en while empty is ignored: no underflow, no state change.
- Simultaneous push and pop is always legal, including when full: level is unchanged and the new sample is stored.
- Push while full with no pop: the sample is dropped and overflow is set. overflow stays set until ovf_clr or RST.
- ovf_clr coincident with a new drop: the set wins.
- RST mid-stream: all in-flight averages are discarded and the next accepted sample restarts warm-up.

Optional Feature:
- Macro: ENV_SMOOTHER_PEAK_EN.
- With the macro defined, extra ports exist:
  - peak_value out DATA_W: running maximum of all smoothed samples pushed, including dropped ones.
  - peak_clr in 1: clears peak_value.
- peak_value resets to 0. peak_clr together with a push loads that push's value.
- Without the macro the ports and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared constants file env_defs: DATA_W, Q2.29 fraction-bit count (29), LOG2 helper macro, and the saturation constant 0x7FFFFFFF.
- One sub-module: sync_fifo (DATA_W x FIFO_DEPTH, registered read, full/empty/level, push-drop-when-full), reusable elsewhere in the design.
- The moving-average datapath stays in the top module.

Test Plan:
- Warm-up, WIN_LEN=4: push 4,8,12,16 -> FIFO receives 1,3,6,10. Next push 20 -> 14 (hist 8..20). Each entry appears at the FIFO two edges after acceptance.
- Wrap-around, WIN_LEN=4: push 0x40 twelve times back-to-back -> outputs 0x10,0x20,0x30 then 0x40 repeated. No throughput gap.
- Saturation: push 0x80000000 with WIN_LEN=4 from reset -> output 0x1FFFFFFF. Push 0xFFFFFFF0 -> treated as 0x7FFFFFFF.
- FIFO full/overflow, FIFO_DEPTH=4, no reads:
  - 5 averages pushed -> full=1, level=4, overflow=1, first 4 values retained in order.
  - Push+pop while full -> level stays 4, no new overflow.
  - ovf_clr -> overflow=0.
- Empty read: rd_en for 3 cycles with empty=1 -> rd_valid stays 0, rd_data unchanged, level 0.
- Reset mid-stream: after 6 pushes, assert RST one cycle -> empty=1, level=0. Then push 8 -> 2 (WIN_LEN=4), proving the history was discarded. With ENV_SMOOTHER_PEAK_EN, peak_value=0 after RST.
